// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin arbiter that shares one FIFO write port among NREQ producers.
//   The winner keeps the port for up to BURST beats. Each accepted beat is
//   acknowledged combinationally and written to the FIFO one cycle later
//   through a registered stage. Beats stall while the FIFO's 3/4-full flag
//   is high.
//
// Ports
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset
//   req         per-requester beat available (held with data until acked)
//   req_data    requester i data in bits [i*WIDTH +: WIDTH]
//   ack         combinational: beat of requester i accepted this cycle
//   grant       registered one-hot owner, all-zero while idle
//   fifo_full   FIFO 3/4 threshold flag
//   fifo_wr_en  registered FIFO write strobe
//   fifo_data   registered FIFO write data
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no owner; scan req from ptr and grant on the next edge
// S_BURST | owner holds the port; one beat per ack until BURST or release

module fifo_wr_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int BURST = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       ack,
  output logic [NREQ-1:0]       grant,
  input  logic                  fifo_full,
  output logic                  fifo_wr_en,
  output logic [WIDTH-1:0]      fifo_data
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(BURST - 1);
  localparam logic [PW-1:0] OWNER_MAX = PW'(NREQ - 1);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t          state;
  logic [PW-1:0]   owner;
  logic [PW-1:0]   ptr;
  logic [CW-1:0]   cnt;

  logic [PW-1:0]   sel;
  logic            sel_vld;
  logic [NREQ-1:0] sel_onehot;
  logic [PW-1:0]   owner_nxt;
  logic            owner_req;
  logic [WIDTH-1:0] owner_data;

  // Rotating priority scan: offset k = 0 is the pointer itself, so the
  // requester after the last owner is looked at first.
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!sel_vld && req[j] && (((int'(ptr) + k) % NREQ) == j)) begin
          sel_vld = 1'b1;
          sel     = PW'(j);
        end
      end
    end
  end

  always_comb begin
    sel_onehot = '0;
    owner_req  = 1'b0;
    owner_data = '0;
    ack        = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_onehot[i] = sel_vld && (sel == PW'(i));
      if (owner == PW'(i)) begin
        owner_req  = req[i];
        owner_data = req_data[i*WIDTH +: WIDTH];
      end
      // ack depends only on req, fifo_full and registered state; req_data
      // never reaches it.
      ack[i] = (state == S_BURST) && (owner == PW'(i)) && req[i] && !fifo_full;
    end
  end

  assign owner_nxt = (owner == OWNER_MAX) ? '0 : owner + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      owner      <= '0;
      ptr        <= '0;
      cnt        <= '0;
      grant      <= '0;
      fifo_wr_en <= 1'b0;
      fifo_data  <= '0;
    end else if (state == S_IDLE) begin
      fifo_wr_en <= 1'b0;
      if (sel_vld && !fifo_full) begin
        state <= S_BURST;
        grant <= sel_onehot;
        owner <= sel;
        cnt   <= '0;
      end
    end else begin
      if (|ack) begin
        fifo_wr_en <= 1'b1;
        fifo_data  <= owner_data;
        cnt        <= cnt + 1'b1;
        if (cnt == CNT_LAST) begin
          state <= S_IDLE;
          grant <= '0;
          ptr   <= owner_nxt;
        end
      end else begin
        fifo_wr_en <= 1'b0;
        // Owner dropped its request: give the port back without a beat.
        // A stall on fifo_full alone keeps the grant indefinitely.
        if (!owner_req) begin
          state <= S_IDLE;
          grant <= '0;
          ptr   <= owner_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int BURST = 4;

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] req_data = '0;
  logic                  fifo_full = 1'b0;
  logic [NREQ-1:0]       ack;
  logic [NREQ-1:0]       grant;
  logic                  fifo_wr_en;
  logic [WIDTH-1:0]      fifo_data;

  fifo_wr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .BURST(BURST)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .req_data   (req_data),
    .ack        (ack),
    .grant      (grant),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_data  (fifo_data)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: who owns the port, how many beats it has had, where the
  // next scan starts, and the writes the FIFO should still receive.
  int               m_owner = -1;
  int               m_ptr   = 0;
  int               m_cnt   = 0;
  int               m_scan;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] m_last = '0;
  logic [WIDTH-1:0] e_data;
  logic             prev_ack = 1'b0;
  logic [NREQ-1:0]  e_grant;
  logic [NREQ-1:0]  e_ack;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard
  always begin
    @(negedge clk or negedge reset_n);
    if (!reset_n) begin
      #1;
      chk("reset_grant", 32'(grant), 32'd0);
      chk("reset_ack", 32'(ack), 32'd0);
      chk("reset_wr_en", 32'(fifo_wr_en), 32'd0);
      chk("reset_data", 32'(fifo_data), 32'd0);
      m_owner = -1;
      m_ptr   = 0;
      m_cnt   = 0;
      exp_q.delete();
      m_last   = '0;
      prev_ack = 1'b0;
    end else begin
      e_grant = (m_owner < 0) ? '0 : (NREQ'(1) << m_owner);
      e_ack   = '0;
      if (m_owner >= 0 && ((req >> m_owner) & NREQ'(1)) != '0 && !fifo_full)
        e_ack = e_grant;

      chk("grant", 32'(grant), 32'(e_grant));
      chk("ack", 32'(ack), 32'(e_ack));
      chk("wr_en", 32'(fifo_wr_en), 32'(prev_ack));
      if (fifo_wr_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL write_unexpected: got data 0x%0h with no beat pending at %0t", fifo_data, $time);
        end else begin
          e_data = exp_q.pop_front();
          chk("fifo_data", 32'(fifo_data), 32'(e_data));
          m_last = e_data;
        end
      end else begin
        chk("fifo_data_hold", 32'(fifo_data), 32'(m_last));
      end
      prev_ack = (e_ack != '0);

      // Advance the model to what should hold after the next rising edge.
      if (m_owner < 0) begin
        if (req != '0 && !fifo_full) begin
          for (int k = 0; k < NREQ; k++) begin
            m_scan = (m_ptr + k) % NREQ;
            if (m_owner < 0 && ((req >> m_scan) & NREQ'(1)) != '0) begin
              m_owner = m_scan;
              m_cnt   = 0;
            end
          end
        end
      end else if (e_ack != '0) begin
        exp_q.push_back(WIDTH'(req_data >> (m_owner * WIDTH)));
        m_cnt++;
        if (m_cnt == BURST) begin
          m_ptr   = (m_owner + 1) % NREQ;
          m_owner = -1;
        end
      end else if (((req >> m_owner) & NREQ'(1)) == '0) begin
        m_ptr   = (m_owner + 1) % NREQ;
        m_owner = -1;
      end
    end
  end

  // One cycle of producer behaviour: an acked beat is replaced by a new one
  // or the request is dropped; an idle producer may raise a new request.
  task automatic step(input int p_keep, input int p_raise, input int p_full);
    logic [NREQ-1:0] ack_s;
    @(negedge clk);
    ack_s = ack;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (ack_s[i]) begin
        if (int'($urandom_range(99)) < p_keep)
          req_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
        else
          req[i] = 1'b0;
      end else if (!req[i] && int'($urandom_range(99)) < p_raise) begin
        req[i] = 1'b1;
        req_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
      end
    end
    fifo_full = (int'($urandom_range(99)) < p_full);
  endtask

  initial begin : stim
    logic [NREQ-1:0]  ack_s;
    logic [WIDTH-1:0] val;

    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Single requester streaming 0x10..0x15
    val = 8'h10;
    req[0] = 1'b1;
    req_data[0 +: WIDTH] = val;
    for (int c = 0; c < 40 && req[0]; c++) begin
      @(negedge clk);
      ack_s = ack;
      @(posedge clk);
      #1;
      if (ack_s[0]) begin
        if (val == 8'h15) req[0] = 1'b0;
        else begin
          val = val + 8'd1;
          req_data[0 +: WIDTH] = val;
        end
      end
    end
    repeat (3) step(0, 0, 0);

    // All requesters busy: pure round robin
    repeat (60) step(100, 100, 0);
    // Mixed traffic with occasional backpressure and early releases
    repeat (500) step(70, 40, 15);
    // Heavy backpressure
    repeat (200) step(85, 60, 50);

    // Full flag while idle blocks the grant
    @(posedge clk);
    #1 req = '0;
    fifo_full = 1'b1;
    repeat (BURST + 3) @(posedge clk);
    #1 req = 4'b0011;
    req_data[0 +: WIDTH] = 8'h5A;
    req_data[WIDTH +: WIDTH] = 8'hA5;
    repeat (4) @(posedge clk);
    #1 fifo_full = 1'b0;
    repeat (20) step(60, 30, 10);

    // Asynchronous reset in the middle of a burst
    @(posedge clk);
    #1 req = '0;
    fifo_full = 1'b0;
    repeat (BURST + 3) @(posedge clk);
    #1 req = 4'b0100;
    req_data[2*WIDTH +: WIDTH] = 8'hA1;
    @(posedge clk);
    @(posedge clk);
    #1 req_data[2*WIDTH +: WIDTH] = 8'hA2;
    #2 reset_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    req = 4'b1100;
    req_data[3*WIDTH +: WIDTH] = 8'hB3;
    repeat (150) step(70, 40, 15);

    @(posedge clk);
    #1 req = '0;
    fifo_full = 1'b0;
    repeat (BURST + 4) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
